mult_hilo_ctrl: RTL and testbench

MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

---
 rtl/mult_hilo_pkg.sv | 12 +
 rtl/mult_hilo_ctrl_if.sv | 25 ++
 rtl/mult_hilo_ctrl_hilo_regs.sv | 33 +++
 rtl/mult_hilo_ctrl.sv | 96 +++++++++
 tb/tb_mult_hilo_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_hilo_pkg.sv
// Shared types and constants for the HI/LO multiply controller.
package mult_hilo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// Control-unit / multiplier bus of the HI/LO controller; slave is the controller side.
interface mult_hilo_ctrl_if;
  logic        mult_req;
  logic        mult_work;
  logic [63:0] mul_in;
  logic        end_mult;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] wr_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        timeout;

  modport master (
    output mult_req, mul_in, end_mult, hi_write, lo_write, wr_data,
    input  mult_work, hi, lo, busy, done, timeout
  );

  modport slave (
    input  mult_req, mul_in, end_mult, hi_write, lo_write, wr_data,
    output mult_work, hi, lo, busy, done, timeout
  );
endinterface

// File: rtl/mult_hilo_ctrl_hilo_regs.sv
// HI/LO architectural registers; a captured product has priority over MTHI/MTLO writes.
module hilo_regs (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cap,
  input  logic [63:0] i_product,
  input  logic        i_hi_we,
  input  logic        i_lo_we,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_cap) begin
      r_hi <= i_product[63:32];
      r_lo <= i_product[31:0];
    end else begin
      if (i_hi_we) r_hi <= i_wr_data;
      if (i_lo_we) r_lo <= i_wr_data;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// MULT sequencing FSM (IDLE/RUN/DONE) in front of the HI/LO registers.
// Optional RUN-state abort counter enabled by MULT_TIMEOUT_EN.
module mult_hilo_ctrl
  import mult_hilo_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic              Clk,
  input logic              reset,
  mult_hilo_ctrl_if.slave  bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e r_state;
  state_e w_state_d;
  logic   w_cap;
  logic   w_hi_we;
  logic   w_lo_we;

`ifdef MULT_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_timeout;
  logic          w_abort;
`endif

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_cap     = 1'b0;
`ifdef MULT_TIMEOUT_EN
    w_abort   = 1'b0;
`endif
    unique case (r_state)
      IDLE: if (bus.mult_req) w_state_d = RUN;
      RUN: begin
        if (bus.end_mult) begin
          w_cap     = 1'b1;
          w_state_d = DONE;
        end
`ifdef MULT_TIMEOUT_EN
        // A product arriving on the terminal count still wins.
        else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_abort   = 1'b1;
          w_state_d = IDLE;
        end
`endif
      end
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

`ifdef MULT_TIMEOUT_EN
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= (r_state == RUN) ? r_cnt + CW'(1) : '0;
      r_timeout <= w_abort;
    end
  end
  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

  // MTHI/MTLO are dropped while a product is pending.
  assign w_hi_we = bus.hi_write && (r_state != RUN);
  assign w_lo_we = bus.lo_write && (r_state != RUN);

  assign bus.mult_work = (r_state == RUN);
  assign bus.busy      = (r_state == RUN);
  assign bus.done      = (r_state == DONE);

  hilo_regs u_hilo_regs (
    .i_clk     (Clk),
    .i_rst_n   (reset),
    .i_cap     (w_cap),
    .i_product (bus.mul_in),
    .i_hi_we   (w_hi_we),
    .i_lo_we   (w_lo_we),
    .i_wr_data (bus.wr_data),
    .o_hi      (bus.hi),
    .o_lo      (bus.lo)
  );

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Self-checking bench for mult_hilo_ctrl: vector table, directed corners, random transactions.
module tb_mult_hilo_ctrl;

`ifdef MULT_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 64;
`endif

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_hilo_ctrl_if u_if ();

  mult_hilo_ctrl #(.TIMEOUT_CYCLES(TO)) u_dut (
    .Clk   (clk),
    .reset (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        hw;
    logic        lw;
    logic        em;
    logic [31:0] data;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.mult_req = 1'b0;
    u_if.end_mult = 1'b0;
    u_if.hi_write = 1'b0;
    u_if.lo_write = 1'b0;
  endtask

  // One multiply of lat RUN cycles; spur injects ignored writes/requests while busy.
  task automatic run_mult(input int lat, input logic [63:0] prod, input logic spur,
                          input string nm);
    int busy_cnt = 0;
    int to_cnt   = 0;
    u_if.mult_req = 1'b1;
    tick();
    u_if.mult_req = 1'b0;
    for (int k = 0; k < lat; k++) begin
      busy_cnt += int'(u_if.busy && u_if.mult_work);
      to_cnt   += int'(u_if.timeout);
      if (spur) begin
        u_if.hi_write = 1'($urandom);
        u_if.lo_write = 1'($urandom);
        u_if.mult_req = 1'($urandom);
        u_if.wr_data  = $urandom;
      end
      u_if.mul_in   = (k == lat - 1) ? prod : 64'({$urandom, $urandom});
      u_if.end_mult = (k == lat - 1);
      tick();
    end
    idle_inputs();
    m_hi = prod[63:32];
    m_lo = prod[31:0];
    check({nm, " busy_cycles"}, 64'(busy_cnt), 64'(lat));
    check({nm, " done"}, {63'd0, u_if.done}, 64'd1);
    check({nm, " hilo"}, {u_if.hi, u_if.lo}, {m_hi, m_lo});
    u_if.mult_req = spur;
    tick();
    u_if.mult_req = 1'b0;
    to_cnt += int'(u_if.timeout);
    check({nm, " done_once"}, {63'd0, u_if.done}, 64'd0);
    check({nm, " idle_after"}, {63'd0, u_if.busy}, 64'd0);
    check({nm, " no_timeout"}, 64'(to_cnt), 64'd0);
  endtask

  initial begin
    vec_t vecs[6];
    idle_inputs();
    u_if.mul_in  = '0;
    u_if.wr_data = '0;
    rst_n = 1'b0;
    #2;
    check("reset hi", 64'(u_if.hi), 64'd0);
    check("reset lo", 64'(u_if.lo), 64'd0);
    check("reset outs", {60'd0, u_if.mult_work, u_if.busy, u_if.done, u_if.timeout}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // First request right after reset release, 33 RUN cycles.
    run_mult(33, 64'h12345678_9ABCDEF0, 1'b0, "basic33");

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h9ABCDEF0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h00000005, 32'hDEADBEEF, 32'h00000005};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h11111111, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h00000000, 32'hA5A5A5A5, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      u_if.hi_write = vecs[i].hw;
      u_if.lo_write = vecs[i].lw;
      u_if.end_mult = vecs[i].em;
      u_if.mul_in   = 64'hCAFEF00D_0BADC0DE;
      u_if.wr_data  = vecs[i].data;
      tick();
      idle_inputs();
      check($sformatf("vec%0d hilo", i), {u_if.hi, u_if.lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
      check($sformatf("vec%0d busy", i), {63'd0, u_if.busy}, 64'd0);
    end

    // Write during RUN is discarded; product 0 lands.
    u_if.mult_req = 1'b1;
    tick();
    u_if.mult_req = 1'b0;
    u_if.hi_write = 1'b1;
    u_if.wr_data  = 32'hFFFFFFFF;
    tick();
    u_if.hi_write = 1'b0;
    check("runwr hi_hold", 64'(u_if.hi), 64'hA5A5A5A5);
    u_if.mul_in   = 64'd0;
    u_if.end_mult = 1'b1;
    tick();
    u_if.end_mult = 1'b0;
    check("runwr hilo", {u_if.hi, u_if.lo}, 64'd0);
    check("runwr done", {63'd0, u_if.done}, 64'd1);
    tick();

    // Request and MTHI together: write lands, then product overwrites.
    u_if.mult_req = 1'b1;
    u_if.hi_write = 1'b1;
    u_if.wr_data  = 32'h0000BEEF;
    tick();
    idle_inputs();
    check("reqwr hi", 64'(u_if.hi), 64'h0000BEEF);
    check("reqwr busy", {63'd0, u_if.busy}, 64'd1);
    u_if.mul_in   = 64'h01020304_05060708;
    u_if.end_mult = 1'b1;
    tick();
    u_if.end_mult = 1'b0;
    check("reqwr hilo", {u_if.hi, u_if.lo}, 64'h01020304_05060708);
    tick();

    // Reset in the middle of RUN aborts the multiply.
    u_if.mult_req = 1'b1;
    tick();
    u_if.mult_req = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst hilo", {u_if.hi, u_if.lo}, 64'd0);
    check("midrst outs", {61'd0, u_if.mult_work, u_if.busy, u_if.done}, 64'd0);
    #1 rst_n = 1'b1;
    u_if.mul_in   = 64'hFFFF0000_FFFF0000;
    u_if.end_mult = 1'b1;
    tick();
    u_if.end_mult = 1'b0;
    check("midrst late_end", {61'd0, u_if.busy, u_if.done, u_if.timeout}, 64'd0);
    check("midrst hilo_hold", {u_if.hi, u_if.lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;

`ifdef MULT_TIMEOUT_EN
    begin
      int busy_cnt = 0;
      m_hi = 32'h600D600D;
      u_if.hi_write = 1'b1;
      u_if.wr_data  = m_hi;
      tick();
      u_if.hi_write = 1'b0;
      u_if.mult_req = 1'b1;
      tick();
      u_if.mult_req = 1'b0;
      for (int k = 0; k < int'(TO); k++) begin
        busy_cnt += int'(u_if.busy);
        check($sformatf("to early_pulse%0d", k), {63'd0, u_if.timeout}, 64'd0);
        tick();
      end
      check("to busy_cycles", 64'(busy_cnt), 64'(TO));
      check("to pulse", {62'd0, u_if.timeout, u_if.busy}, 64'd2);
      check("to hilo_hold", {u_if.hi, u_if.lo}, {m_hi, m_lo});
      tick();
      check("to pulse_once", {63'd0, u_if.timeout}, 64'd0);
    end
    run_mult(int'(TO), 64'h0BEEF000_0000FEED, 1'b0, "to_terminal_win");
`endif

    // Random transactions against the transaction-level HI/LO model.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        logic hw, lw;
        logic [31:0] d;
        hw = 1'($urandom);
        lw = 1'($urandom);
        d  = $urandom;
        u_if.hi_write = hw;
        u_if.lo_write = lw;
        u_if.end_mult = 1'($urandom);
        u_if.mul_in   = 64'({$urandom, $urandom});
        u_if.wr_data  = d;
        tick();
        idle_inputs();
        if (hw) m_hi = d;
        if (lw) m_lo = d;
        check($sformatf("rnd%0d write", t), {u_if.hi, u_if.lo}, {m_hi, m_lo});
      end else begin
        run_mult($urandom_range(1, (TO < 12) ? int'(TO) : 12), 64'({$urandom, $urandom}),
                 1'b1, $sformatf("rnd%0d mult", t));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
